// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef logic                        bit_t;
    typedef logic [UART_DATA_BITS-1:0]   fifo_in;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff
    import uart_rx_pkg::*;
#(
    parameter bit_t RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  bit_t d,
    output bit_t q
);

    bit_t meta;

    // Two-stage capture; both stages come out of reset at RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled framing, single-cycle FIFO push,
// framing-error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    input  logic                      full,
    output logic [UART_DATA_BITS-1:0] datainput,
    output logic                      push,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                      rx_s;
    logic [2:0]                state, state_nx;
    logic [CNT_W-1:0]          cnt, cnt_nx;
    logic [2:0]                idx, idx_nx;
    logic [UART_DATA_BITS-1:0] sh, sh_nx;
    logic [UART_DATA_BITS-1:0] data_nx;
    logic                      push_nx, frame_err_nx, overrun_nx, busy_nx;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            datainput <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            sh        <= sh_nx;
            datainput <= data_nx;
            push      <= push_nx;
            frame_err <= frame_err_nx;
            overrun   <= overrun_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        idx_nx       = idx;
        sh_nx        = sh;
        data_nx      = datainput;
        push_nx      = 1'b0;
        frame_err_nx = 1'b0;
        overrun_nx   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nx = '0;
                    idx_nx = '0;
                    // A start bit that is high again by mid-bit was a glitch.
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_nx = CNT_W'(cnt + 1'b1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    sh_nx[idx] = rx_s;
                    cnt_nx     = '0;
                    idx_nx     = 3'(idx + 1'b1);
                    if (idx == 3'd7) begin
                        state_nx = S_STOP;
                    end
                end else begin
                    cnt_nx = CNT_W'(cnt + 1'b1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = S_IDLE;
                        if (full) begin
                            overrun_nx = 1'b1;
                        end else begin
                            push_nx = 1'b1;
                            data_nx = sh;
                        end
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_nx = CNT_W'(cnt + 1'b1);
                end
            end
            S_WAIT_HIGH: begin
                // Hold off after a framing error until the line is released.
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// timing, back-to-back, glitch, break, overrun and mid-frame reset cases.
module tb_uart_rx;

    localparam int N = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       full;
    logic [7:0] datainput;
    logic       push;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Monitor state
    logic [7:0] push_data_q[$];
    int         push_time_q[$];
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    int         viol         = 0;
    int         strobe_sum   = 0;
    logic       prev_strobe  = 1'b0;
    logic       prev_busy    = 1'b0;
    logic       busy_at_push = 1'b0;
    logic       busy_before_push = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        int         exp_push;
        int         exp_ferr;
        int         exp_ovr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .full      (full),
        .datainput (datainput),
        .push      (push),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes at the falling edge and flag exclusivity violations.
    always @(negedge clk) begin
        strobe_sum = int'(push) + int'(frame_err) + int'(overrun);
        if (strobe_sum > 1) viol++;
        if (strobe_sum > 0 && prev_strobe) viol++;
        prev_strobe = (strobe_sum > 0);
        if (push) begin
            push_data_q.push_back(datainput);
            push_time_q.push_back(cyc);
            busy_at_push     = busy;
            busy_before_push = prev_busy;
        end
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
        prev_busy = busy;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Drive one bit for N cycles; called at a falling edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t_start);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, t1, p0, f0, o0;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 0, 0, 1, 8'hA5};
        vecs[4] = '{8'h96, 1'b0, 1'b0, 0, 1, 0, 8'hA5};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 1, 0, 0, 8'h01};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 0, 0, 1, 8'h01};

        reset = 1'b1;
        rx    = 1'b1;
        full  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(datainput), 32'h00);
        check("reset_push",  32'(push),      32'h0);
        check("reset_ferr",  32'(frame_err), 32'h0);
        check("reset_ovr",   32'(overrun),   32'h0);
        check("reset_busy",  32'(busy),      32'h0);
        reset = 1'b0;
        idle(5);

        // Single frame: latency, data, busy/push alignment
        p0 = push_data_q.size();
        send_frame(8'h55, 1'b1, t0);
        idle(2 * N);
        check("t1_push_count", 32'(push_data_q.size() - p0), 32'd1);
        check("t1_data",       32'(datainput), 32'h55);
        if (push_data_q.size() > p0) begin
            check("t1_latency", 32'(push_time_q[p0] - t0), 32'd155);
            check("t1_busy_at_push",     32'(busy_at_push),     32'h0);
            check("t1_busy_before_push", 32'(busy_before_push), 32'h1);
        end

        // Back-to-back frames with no idle gap
        p0 = push_data_q.size();
        send_frame(8'hA3, 1'b1, t0);
        send_frame(8'h0F, 1'b1, t1);
        idle(2 * N);
        check("t2_push_count", 32'(push_data_q.size() - p0), 32'd2);
        if (push_data_q.size() >= p0 + 2) begin
            check("t2_data0",   32'(push_data_q[p0]),     32'hA3);
            check("t2_data1",   32'(push_data_q[p0 + 1]), 32'h0F);
            check("t2_spacing", 32'(push_time_q[p0 + 1] - push_time_q[p0]), 32'd160);
        end

        // Start-bit glitch
        p0 = push_data_q.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * N);
        check("t3_push", 32'(push_data_q.size() - p0), 32'd0);
        check("t3_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t3_data", 32'(datainput), 32'h0F);
        check("t3_busy", 32'(busy), 32'h0);

        // Framing error followed by a long break
        p0 = push_data_q.size();
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, t0);
        rx = 1'b0;
        repeat (40 * N) @(negedge clk);
        check("t4_busy_in_break", 32'(busy), 32'h1);
        idle(2 * N);
        check("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t4_push", 32'(push_data_q.size() - p0), 32'd0);
        send_frame(8'h81, 1'b1, t0);
        idle(2 * N);
        check("t4_push_after", 32'(push_data_q.size() - p0), 32'd1);
        check("t4_data_after", 32'(datainput), 32'h81);

        // Overrun while FIFO full, then accepted once space frees
        p0 = push_data_q.size();
        o0 = ovr_cnt;
        full = 1'b1;
        send_frame(8'h7E, 1'b1, t0);
        idle(2 * N);
        full = 1'b0;
        check("t5_ovr",  32'(ovr_cnt - o0), 32'd1);
        check("t5_push", 32'(push_data_q.size() - p0), 32'd0);
        check("t5_data", 32'(datainput), 32'h81);
        send_frame(8'h7E, 1'b1, t0);
        idle(2 * N);
        check("t5_push_after", 32'(push_data_q.size() - p0), 32'd1);
        check("t5_data_after", 32'(datainput), 32'h7E);

        // Reset in the middle of data bit 4
        p0 = push_data_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (N / 2) @(negedge clk);
        check("t6_busy_pre_reset", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_data", 32'(datainput), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_strobes", 32'({push, frame_err, overrun}), 32'h0);
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(12 * N);
        check("t6_no_strobe", 32'((push_data_q.size() - p0) + (ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
        send_frame(8'hC6, 1'b1, t0);
        idle(2 * N);
        check("t6_push", 32'(push_data_q.size() - p0), 32'd1);
        check("t6_data", 32'(datainput), 32'hC6);

        // Table of single frames
        for (int v = 0; v < 7; v++) begin
            p0 = push_data_q.size();
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            full = vecs[v].full;
            send_frame(vecs[v].data, vecs[v].stop, t0);
            idle(2 * N);
            full = 1'b0;
            check($sformatf("vec%0d_push", v), 32'(push_data_q.size() - p0), 32'(vecs[v].exp_push));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0),           32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v),  32'(ovr_cnt - o0),            32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d_data", v), 32'(datainput),               32'(vecs[v].exp_data));
        end

        check("strobe_exclusive", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
